icache_direct: RTL
==================

// Module: icache_direct
// PURPOSE
//  Direct-mapped instruction cache between the pipelined MIPS core's fetch stage and main memory.
//  Serves InstrF for PCF in the same cycle on a hit. On a miss it stalls fetch and refills one line,
//  a word at a time, over a req/valid memory handshake. ICacheStall is ORed into the hazard unit's StallF/StallD.
// PARAMETERS
//  LINES  16  number of cache lines; power of 2, >=2
//  WORDS  4   32-bit words per line; power of 2, >=2
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  reset        in   1   synchronous, active-high
//  PCF          in   32  fetch address; bits[1:0] ignored
//  FetchEn      in   1   1 = lookup valid this cycle
//  Inv          in   1   single-cycle pulse: invalidate all lines
//  InstrF       out  32  instruction at PCF; valid when ICacheStall=0
//  ICacheStall  out  1   1 = InstrF not valid, hold PCF
//  MemReq       out  1   word read request
//  MemAddr      out  32  word address of request
//  MemRData     in   32  read data
//  MemRValid    in   1   MemRData valid this cycle; completes current request
// BEHAVIOUR
//  - Address split: offset = PCF[2+log2(WORDS)-1:2], index = next log2(LINES) bits, tag = remaining upper bits.
//  - Hit = FetchEn & valid[index] & (tag_ram[index]==tag). Combinational read path; zero-cycle hit latency.
//  - FSM states: IDLE, REFILL.
//    - IDLE: ICacheStall = FetchEn & ~hit, combinational. On a miss, latch tag/index, clear word count,
//      and go to REFILL next cycle.
//    - REFILL: ICacheStall=1, MemReq=1, MemAddr={ltag,lindex,cnt,2'b00}.
//      - Each MemRValid cycle: write MemRData into data[lindex][cnt], then cnt++.
//      - On the rvalid with cnt==WORDS-1: write tag, set valid[lindex] (unless Inv seen during the refill),
//        and return to IDLE.
//    - Addresses are issued in ascending order from the line base; no critical-word-first.
//  - Miss penalty = 1 cycle + the sum of per-word memory latencies. The re-lookup in IDLE hits the next cycle.
//  - PCF is ignored during REFILL; the refill uses only the latched tag/index. The core holds PCF while stalled.
//  - FetchEn=0 in IDLE: ICacheStall=0, no refill starts. InstrF is don't-care.
//  - Inv:
//    - In IDLE: all valid bits clear at the clock edge. A lookup in the same cycle still uses the
//      pre-edge valid bits.
//    - In REFILL: all valid bits clear; the sticky inv_pend flag is set so the completing line is NOT
//      marked valid. inv_pend clears on return to IDLE.
//  - Reset (any state):
//    - FSM goes to IDLE; all valid bits, cnt and inv_pend clear; the data/tag RAMs are untouched.
//    - While reset=1, MemReq=0 and ICacheStall=0.
//    - A refill aborted mid-line leaves that line invalid. Outstanding memory responses after reset are ignored.
//  - MemRValid while not in REFILL: ignored.
//  - Hit to a line currently being refilled cannot occur, because valid is set only at refill completion.
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//    - Adds outputs HitCount[31:0] and MissCount[31:0].
//    - HitCount increments on each IDLE cycle with FetchEn & hit.
//    - MissCount increments on each IDLE->REFILL transition.
//    - Both counters clear on reset and wrap modulo 2^32.
//  ICACHE_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  - Package mips_cache_pkg: typedef enum logic {IC_IDLE, IC_REFILL} icache_state_t; function clog2 helpers;
//    localparam WORD_BYTES=4.
//  - Sub-module icache_data_ram:
//    - LINES*WORDS x 32 array.
//    - Asynchronous read on {index,offset}.
//    - Synchronous write on {lindex,cnt}.
//  - The tag/valid arrays and the FSM stay in icache_direct.
// TESTING (LINES=16, WORDS=4, memory model returns MemRValid 2 cycles after MemReq per word)
//  1. Cold miss:
//     - Stimulus: release reset; FetchEn=1, PCF=0x0.
//     - Response: ICacheStall=1; MemAddr sequence 0x0,0x4,0x8,0xC. The cycle after the 4th rvalid,
//       ICacheStall=0 and InstrF=mem[0x0].
//  2. Hits:
//     - Stimulus: after test 1, PCF=0x4,0x8,0xC on consecutive cycles.
//     - Response: ICacheStall=0 each cycle; InstrF=mem[PCF]; MemReq never asserted.
//  3. Conflict:
//     - Stimulus: PCF=0x100 (index 0, tag 1).
//     - Response: miss; refill 0x100..0x10C. Then PCF=0x0 misses and refills 0x0..0xC again.
//  4. Reset mid-refill:
//     - Stimulus: assert reset 1 cycle on the cycle after the 2nd rvalid of a refill.
//     - Response: next cycle MemReq=0; PCF=0x0 misses again with a full 4-word refill from 0x0.
//  5. Invalidate:
//     - Stimulus (a): Inv pulse with line 0 valid.
//       Response (a): next cycle PCF=0x0 misses.
//     - Stimulus (b): Inv during a refill of 0x40.
//       Response (b): the refill completes (4 words) and the re-lookup misses again.
//  6. Stats (ICACHE_STATS_EN):
//     - Stimulus: run tests 1+2.
//     - Response: MissCount=1, HitCount=4 (the re-lookup of 0x0 plus 3 hits); reset returns both to 0.

Source files
------------

// File: rtl/mips_cache_pkg.sv
// Shared types and helpers for the MIPS instruction cache.
package mips_cache_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic {
        IC_IDLE   = 1'b0,
        IC_REFILL = 1'b1
    } icache_state_t;

    // Ceiling log2 for elaboration-time width computation (returns 0 for value<=1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction cache data array: LINES*WORDS 32-bit words,
// asynchronous read for the zero-latency hit path, synchronous refill write.
module icache_data_ram
    import mips_cache_pkg::*;
#(
    parameter int   LINES  = 16,
    parameter int   WORDS  = 4,
    localparam int  ADDR_W = clog2(LINES) + clog2(WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [LINES*WORDS];

    // Refill write port: one word per accepted memory response.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped instruction cache for the fetch stage.
// Zero-cycle hit path; on a miss the line is refilled word by word in
// ascending address order over a req/valid memory handshake.
// Optional feature: define ICACHE_STATS_EN to add HitCount/MissCount outputs.
module icache_direct
    import mips_cache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        FetchEn,
    input  logic        Inv,
    output logic [31:0] InstrF,
    output logic        ICacheStall,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic [31:0] MemRData,
    input  logic        MemRValid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] HitCount,
    output logic [31:0] MissCount
`endif
);

    localparam int LSB_W = clog2(WORD_BYTES);
    localparam int OFF_W = clog2(WORDS);
    localparam int IDX_W = clog2(LINES);
    localparam int TAG_W = 32 - LSB_W - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(WORDS - 1);

    // Fetch address fields
    logic [OFF_W-1:0] w_offset;
    logic [IDX_W-1:0] w_index;
    logic [TAG_W-1:0] w_tag;
    logic             w_unused_pcf;

    assign w_offset     = PCF[LSB_W +: OFF_W];
    assign w_index      = PCF[LSB_W + OFF_W +: IDX_W];
    assign w_tag        = PCF[31 -: TAG_W];
    assign w_unused_pcf = ^PCF[LSB_W-1:0];

    // Tag/valid storage and refill bookkeeping
    icache_state_t    r_state;
    icache_state_t    w_state_next;
    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag_ram [LINES];
    logic [TAG_W-1:0] r_ltag;
    logic [IDX_W-1:0] r_lindex;
    logic [OFF_W-1:0] r_cnt;
    logic             r_inv_pend;

    logic w_hit;
    logic w_stall;
    logic w_mem_req;
    logic w_start;
    logic w_word_we;
    logic w_line_done;

    assign w_hit = FetchEn & r_valid[w_index] & (r_tag_ram[w_index] == w_tag);

    // Next-state and handshake decode; reset forces both outputs low.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_mem_req    = 1'b0;
        w_start      = 1'b0;
        w_word_we    = 1'b0;
        w_line_done  = 1'b0;
        if (!reset) begin
            case (r_state)
                IC_IDLE: begin
                    w_stall = FetchEn & ~w_hit;
                    if (FetchEn && !w_hit) begin
                        w_start      = 1'b1;
                        w_state_next = IC_REFILL;
                    end
                end
                IC_REFILL: begin
                    w_stall   = 1'b1;
                    w_mem_req = 1'b1;
                    if (MemRValid) begin
                        w_word_we = 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            w_line_done  = 1'b1;
                            w_state_next = IC_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IC_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Valid bits: invalidate wins over a completing refill in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || Inv) begin
            r_valid <= '0;
        end else if (w_line_done && !r_inv_pend) begin
            r_valid[r_lindex] <= 1'b1;
        end
    end

    // Sticky invalidate seen during a refill; dropped once back in IDLE.
    always_ff @(posedge clk) begin
        if (reset || r_state == IC_IDLE || w_line_done) begin
            r_inv_pend <= 1'b0;
        end else if (Inv) begin
            r_inv_pend <= 1'b1;
        end
    end

    // Word counter within the line being refilled.
    always_ff @(posedge clk) begin
        if (reset || w_start) begin
            r_cnt <= '0;
        end else if (w_word_we) begin
            r_cnt <= r_cnt + OFF_W'(1);
        end
    end

    // Latch the missing line's tag/index; PCF is ignored for the rest of the refill.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_ltag   <= w_tag;
            r_lindex <= w_index;
        end
    end

    // Tag RAM is written only when the whole line has arrived.
    always_ff @(posedge clk) begin
        if (w_line_done) begin
            r_tag_ram[r_lindex] <= r_ltag;
        end
    end

    icache_data_ram #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_data_ram (
        .clk     (clk),
        .i_we    (w_word_we),
        .i_waddr ({r_lindex, r_cnt}),
        .i_wdata (MemRData),
        .i_raddr ({w_index, w_offset}),
        .o_rdata (InstrF)
    );

    assign ICacheStall = w_stall;
    assign MemReq      = w_mem_req;
    assign MemAddr     = {r_ltag, r_lindex, r_cnt, LSB_W'(0)};

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Hit/miss statistics, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (r_state == IC_IDLE && w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_start) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign HitCount  = r_hit_count;
    assign MissCount = r_miss_count;
`endif

endmodule
